// File: rtl/mac_feed_scheduler_pkg.sv
// Shared NPU definitions: scheduler state encoding and feeder slot arithmetic.
package npu_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_RD   = 3'd2,
      ISSUE     = 3'd3,
      COMPLETE  = 3'd4,
      WAIT_DONE = 3'd5
   } sched_state_e;

   // Number of whole input vectors that fit in one feeder output vector.
   function automatic int maxSlots(input int outDim, input int inDim);
      return outDim / inDim;
   endfunction

endpackage

// File: rtl/mac_feed_scheduler_if.sv
// Vector-buffer read port and feeder handshake seen by the MAC feed scheduler.
interface mac_feed_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_DIM     = 3,
   parameter int ADDR_WIDTH = 8
);

   logic                         buf_rd_en;
   logic [ADDR_WIDTH-1:0]        buf_addr;
   logic [IN_DIM*DATA_WIDTH-1:0] buf_rdata;
   logic                         vector_valid;
   logic [IN_DIM*DATA_WIDTH-1:0] in_vector;
   logic                         feeder_ready;
   logic                         vectors_complete;
   logic                         feeder_all_done;

   modport master (
      output buf_rd_en, buf_addr, vector_valid, in_vector, vectors_complete,
      input  buf_rdata, feeder_ready, feeder_all_done
   );

   modport slave (
      input  buf_rd_en, buf_addr, vector_valid, in_vector, vectors_complete,
      output buf_rdata, feeder_ready, feeder_all_done
   );

endinterface

// File: rtl/mac_feed_scheduler.sv
// Sequences buffer reads into the MAC feeder for one layer pass.
// Optional perf counters (stall_cycles_o, pass_cycles_o) under MAC_SCHED_PERF_EN.
module mac_feed_scheduler
   import npu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IN_DIM     = 3,
   parameter int OUT_DIM    = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [CNT_WIDTH-1:0]  num_vectors_i,
   input  logic                  abort_i,
   mac_feed_if.master            bus,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_overflow_o
`ifdef MAC_SCHED_PERF_EN
   ,
   output logic [15:0]           stall_cycles_o,
   output logic [15:0]           pass_cycles_o
`endif
);

   localparam int                   VEC_W       = IN_DIM * DATA_WIDTH;
   localparam int                   MAX_SLOTS   = maxSlots(OUT_DIM, IN_DIM);
   localparam logic [CNT_WIDTH-1:0] MAX_SLOTS_C = CNT_WIDTH'(MAX_SLOTS);

   sched_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] baseAddr_q, baseAddr_d;
   logic [CNT_WIDTH-1:0]  effN_q, effN_d;
   logic [CNT_WIDTH-1:0]  idx_q, idx_d;
   logic [VEC_W-1:0]      inVector_q, inVector_d;
   logic                  errOverflow_q, errOverflow_d;
   logic                  done_q, done_d;

   // Next-state and handshake decode; abort preempts everything except IDLE.
   always_comb begin
      state_d               = state_q;
      baseAddr_d            = baseAddr_q;
      effN_d                = effN_q;
      idx_d                 = idx_q;
      inVector_d            = inVector_q;
      errOverflow_d         = errOverflow_q;
      done_d                = 1'b0;
      bus.buf_rd_en         = 1'b0;
      bus.buf_addr          = '0;
      bus.vector_valid      = 1'b0;
      bus.vectors_complete  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               baseAddr_d = base_addr_i;
               idx_d      = '0;
               if (num_vectors_i > MAX_SLOTS_C) begin
                  effN_d        = MAX_SLOTS_C;
                  errOverflow_d = 1'b1;
               end else begin
                  effN_d        = num_vectors_i;
                  errOverflow_d = 1'b0;
               end
               state_d = (effN_d == '0) ? COMPLETE : FETCH;
            end
         end
         FETCH: begin
            bus.buf_rd_en = 1'b1;
            bus.buf_addr  = baseAddr_q + ADDR_WIDTH'(idx_q);
            state_d       = abort_i ? COMPLETE : WAIT_RD;
         end
         WAIT_RD: begin
            inVector_d = bus.buf_rdata;
            state_d    = abort_i ? COMPLETE : ISSUE;
         end
         ISSUE: begin
            bus.vector_valid = 1'b1;
            if (bus.feeder_ready) begin
               idx_d   = idx_q + CNT_WIDTH'(1);
               state_d = (idx_d == effN_q) ? COMPLETE : FETCH;
            end
            if (abort_i) begin
               state_d = COMPLETE;
            end
         end
         COMPLETE: begin
            bus.vectors_complete = 1'b1;
            state_d              = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (abort_i) begin
               state_d = COMPLETE;
            end else if (bus.feeder_all_done) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         baseAddr_q    <= '0;
         effN_q        <= '0;
         idx_q         <= '0;
         inVector_q    <= '0;
         errOverflow_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         baseAddr_q    <= baseAddr_d;
         effN_q        <= effN_d;
         idx_q         <= idx_d;
         inVector_q    <= inVector_d;
         errOverflow_q <= errOverflow_d;
         done_q        <= done_d;
      end
   end

   assign bus.in_vector  = inVector_q;
   assign busy_o         = (state_q != IDLE);
   assign done_o         = done_q;
   assign err_overflow_o = errOverflow_q;

`ifdef MAC_SCHED_PERF_EN
   logic [15:0] stallCnt_q, stallCnt_d;
   logic [15:0] passCnt_q, passCnt_d;

   // Saturating counters, cleared by an accepted start and frozen once idle.
   always_comb begin
      stallCnt_d = stallCnt_q;
      passCnt_d  = passCnt_q;
      if (state_q == IDLE && start_i) begin
         stallCnt_d = '0;
         passCnt_d  = '0;
      end else begin
         if (state_q == ISSUE && !bus.feeder_ready && stallCnt_q != 16'hFFFF) begin
            stallCnt_d = stallCnt_q + 16'd1;
         end
         if (state_q != IDLE && passCnt_q != 16'hFFFF) begin
            passCnt_d = passCnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
         passCnt_q  <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         passCnt_q  <= passCnt_d;
      end
   end

   assign stall_cycles_o = stallCnt_q;
   assign pass_cycles_o  = passCnt_q;
`endif

endmodule
